spi_slave: RTL and testbench

//  SPI responder (slave), the counterpart of the team's Wishbone SPI master. Exposes the same
//  8-bit Wishbone register map (SPCR/SPSR/data/SPER) and holds 4-deep TX and RX byte FIFOs.

---
 rtl/spi_slave_if.sv | 26 ++
 rtl/spi_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Wishbone register port and SPI pins of the SPI responder.
interface spi_slave_if;
  logic       cyc_i;
  logic       stb_i;
  logic [1:0] adr_i;
  logic       we_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       inta_o;
  logic       sck_i;
  logic       ss_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, dat_i, sck_i, ss_i, mosi_i,
    output dat_o, ack_o, inta_o, miso_o, miso_oe_o
  );

  modport master (
    output cyc_i, stb_i, adr_i, we_i, dat_i, sck_i, ss_i, mosi_i,
    input  dat_o, ack_o, inta_o, miso_o, miso_oe_o
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder with a Wishbone register map and 4-deep TX/RX byte FIFOs.
// SPI pins are oversampled on clk_i; all four CPOL/CPHA modes, MSB first.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  spi_slave_if.slave bus
);
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   ack_q, ack_d, inta_q, inta_d;
  logic [DW-1:0]          dat_q, dat_d;
  logic                   miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic                   spie_q, spie_d, spe_q, spe_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic [1:0]             icnt_q, icnt_d, cnt_q, cnt_d;
  logic                   spif_q, spif_d, wcol_q, wcol_d, rovr_q, rovr_d, tund_q, tund_d;
  logic [DW-1:0]          tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic                   first_q, first_d, skip_q, skip_d;
  logic [DW-1:0]          tx_mem [DEPTH];
  logic [DW-1:0]          rx_mem [DEPTH];
  logic [PW-1:0]          tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic                   tx_push, tx_pop, rx_push, rx_pop, tx_push_req, rx_push_req;

  logic sck_s, ss_s, mosi_s, sck_rise, sck_fall, lead_edge, trail_edge, smp_edge, shf_edge;
  logic ss_fall, ss_rise, bus_req, bus_acc, tx_empty, tx_full, rx_empty, rx_full;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign ss_s       = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign ss_fall    = ~ss_s & ss_prev_q;
  assign ss_rise    = ss_s & ~ss_prev_q;
  // Leading edge moves sck away from its idle (cpol) level.
  assign lead_edge  = cpol_q ? sck_fall : sck_rise;
  assign trail_edge = cpol_q ? sck_rise : sck_fall;
  assign smp_edge   = cpha_q ? trail_edge : lead_edge;
  assign shf_edge   = cpha_q ? lead_edge : trail_edge;

  assign bus_req  = bus.cyc_i & bus.stb_i & ~ack_q;
  assign bus_acc  = bus.cyc_i & bus.stb_i & ack_q;
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  assign bus.ack_o     = ack_q;
  assign bus.dat_o     = dat_q;
  assign bus.inta_o    = inta_q;
  assign bus.miso_o    = miso_q;
  assign bus.miso_oe_o = miso_oe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  always_comb begin
    state_d = state_q;  ack_d = bus_req;  dat_d = dat_q;  miso_d = miso_q;
    spie_d = spie_q;    spe_d = spe_q;    cpol_d = cpol_q; cpha_d = cpha_q;
    icnt_d = icnt_q;    cnt_d = cnt_q;    spif_d = spif_q; wcol_d = wcol_q;
    rovr_d = rovr_q;    tund_d = tund_q;  tx_sh_d = tx_sh_q; rx_sh_d = rx_sh_q;
    bcnt_d = bcnt_q;    first_d = first_q; skip_d = skip_q;
    tx_push = 1'b0; tx_pop = 1'b0; rx_push = 1'b0; tx_push_req = 1'b0; rx_push_req = 1'b0;

    if (bus_req && !bus.we_i) begin
      case (bus.adr_i)
        2'd0:    dat_d = {spie_q, spe_q, 2'b00, cpol_q, cpha_q, 2'b00};
        2'd1:    dat_d = {spif_q, wcol_q, rovr_q, tund_q, tx_full, tx_empty, rx_full, rx_empty};
        2'd2:    dat_d = rx_mem[rx_rp_q[AW-1:0]];
        default: dat_d = {icnt_q, 6'b0};
      endcase
    end
    if (bus_acc && bus.we_i) begin
      case (bus.adr_i)
        2'd0: begin
          spie_d = bus.dat_i[7]; spe_d = bus.dat_i[6]; cpol_d = bus.dat_i[3]; cpha_d = bus.dat_i[2];
        end
        2'd1: begin
          spif_d = spif_q & ~bus.dat_i[7]; wcol_d = wcol_q & ~bus.dat_i[6];
          rovr_d = rovr_q & ~bus.dat_i[5]; tund_d = tund_q & ~bus.dat_i[4];
        end
        2'd2:    tx_push_req = 1'b1;
        default: icnt_d = bus.dat_i[7:6];
      endcase
    end
    rx_pop = bus_acc && !bus.we_i && (bus.adr_i == 2'd2) && !rx_empty;

    case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else begin
          if (tx_empty) begin
            tx_sh_d = 8'hFF;
            tund_d  = 1'b1;
          end else begin
            tx_pop  = 1'b1;
            tx_sh_d = tx_mem[tx_rp_q[AW-1:0]];
          end
          if (!cpha_q) miso_d = tx_sh_d[DW-1];
          bcnt_d  = 3'd7;
          first_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else begin
          // With cpha=0 the trailing edge after the previous byte's last sample is not a shift.
          if (shf_edge) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else if (cpha_q && first_q) begin
              miso_d  = tx_sh_q[DW-1];
              first_d = 1'b0;
            end else begin
              tx_sh_d = {tx_sh_q[DW-2:0], 1'b0};
              miso_d  = tx_sh_q[DW-2];
            end
          end
          if (smp_edge) begin
            rx_sh_d = {rx_sh_q[DW-2:0], mosi_s};
            bcnt_d  = bcnt_q - 3'd1;
            if (bcnt_q == 3'd0) state_d = DONE;
          end
        end
      end
      DONE: begin
        rx_push_req = 1'b1;
        skip_d      = ~cpha_q;
        if (cnt_q == 2'd0) begin
          spif_d = 1'b1;
          cnt_d  = icnt_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
        state_d = ss_rise ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    if (tx_push_req) begin
      if (tx_full && !tx_pop) wcol_d = 1'b1;
      else                    tx_push = 1'b1;
    end
    if (rx_push_req) begin
      if (rx_full && !rx_pop) rovr_d = 1'b1;
      else                    rx_push = 1'b1;
    end
    tx_wp_d   = tx_wp_q + PW'(tx_push);
    tx_rp_d   = tx_rp_q + PW'(tx_pop);
    rx_wp_d   = rx_wp_q + PW'(rx_push);
    rx_rp_d   = rx_rp_q + PW'(rx_pop);
    miso_oe_d = spe_q & ~ss_s;

    if (!spe_q) begin
      state_d = IDLE;
      tx_wp_d = '0; tx_rp_d = '0; rx_wp_d = '0; rx_rp_d = '0;
      spif_d  = 1'b0; wcol_d = 1'b0; rovr_d = 1'b0; tund_d = 1'b0;
      cnt_d   = icnt_d;
    end
    inta_d = spif_d & spie_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;  ack_q <= 1'b0;  dat_q <= '0;  inta_q <= 1'b0;
      miso_q <= 1'b0;   miso_oe_q <= 1'b0;
      spie_q <= 1'b0;   spe_q <= 1'b0;  cpol_q <= 1'b0; cpha_q <= 1'b0;
      icnt_q <= '0;     cnt_q <= '0;
      spif_q <= 1'b0;   wcol_q <= 1'b0; rovr_q <= 1'b0; tund_q <= 1'b0;
      tx_sh_q <= '0;    rx_sh_q <= '0;  bcnt_q <= '0;   first_q <= 1'b0; skip_q <= 1'b0;
      tx_wp_q <= '0;    tx_rp_q <= '0;  rx_wp_q <= '0;  rx_rp_q <= '0;
    end else begin
      state_q <= state_d; ack_q <= ack_d; dat_q <= dat_d; inta_q <= inta_d;
      miso_q <= miso_d;   miso_oe_q <= miso_oe_d;
      spie_q <= spie_d;   spe_q <= spe_d; cpol_q <= cpol_d; cpha_q <= cpha_d;
      icnt_q <= icnt_d;   cnt_q <= cnt_d;
      spif_q <= spif_d;   wcol_q <= wcol_d; rovr_q <= rovr_d; tund_q <= tund_d;
      tx_sh_q <= tx_sh_d; rx_sh_q <= rx_sh_d; bcnt_q <= bcnt_d; first_q <= first_d; skip_q <= skip_d;
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
    end else begin
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= bus.dat_i;
      if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: Wishbone register access plus an SPI master model,
// with scoreboard queues for bytes expected on MISO and bytes expected from the RX FIFO.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int unsigned HALF = 8;

  logic clk = 1'b0;
  logic rst;
  spi_slave_if bus ();

  spi_slave #(.SYNC_STAGES(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] m0, m1;
    logic [7:0] s0, s1;
  } vec_t;

  vec_t       vecs [4];
  int         checks = 0;
  int         errors = 0;
  logic       cpol_m = 1'b0;
  logic       cpha_m = 1'b0;
  logic [7:0] exp_miso_q [$];
  logic [7:0] exp_rx_q [$];
  logic [7:0] d;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic wb_cycle(input logic [1:0] adr, input logic we, input logic [7:0] wd,
                          output logic [7:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack_o && n < 8);
    rd = bus.dat_o;
    check("wb_ack", {7'b0, bus.ack_o}, 8'h01);
    @(negedge clk);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] wd);
    logic [7:0] unused_rd;
    wb_cycle(adr, 1'b1, wd, unused_rd);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [7:0] rd);
    wb_cycle(adr, 1'b0, 8'h00, rd);
  endtask

  task automatic tx_write(input logic [7:0] b);
    wb_write(2'd2, b);
    exp_miso_q.push_back(b);
  endtask

  task automatic rx_read();
    logic [7:0] rd;
    wb_read(2'd2, rd);
    if (exp_rx_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rx_sb_empty actual=%02h expected=none", rd);
    end else begin
      check("rx_byte", rd, exp_rx_q.pop_front());
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_low();
    bus.ss_i = 1'b0;
    half();
    check("miso_oe_low_ss", {7'b0, bus.miso_oe_o}, 8'h01);
  endtask

  task automatic ss_high();
    half();
    bus.ss_i = 1'b1;
    half();
  endtask

  // Master side of one byte; a full byte is compared against the MISO scoreboard.
  task automatic spi_byte(input logic [7:0] tx, input int nbits);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha_m) begin
        bus.mosi_i = tx[i];
        half();
        rx[i] = bus.miso_o;
        bus.sck_i = ~cpol_m;
        half();
        bus.sck_i = cpol_m;
      end else begin
        half();
        bus.sck_i  = ~cpol_m;
        bus.mosi_i = tx[i];
        half();
        rx[i] = bus.miso_o;
        bus.sck_i = cpol_m;
      end
    end
    if (nbits == 8) begin
      if (exp_miso_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL miso_sb_empty actual=%02h expected=none", rx);
      end else begin
        check("miso_byte", rx, exp_miso_q.pop_front());
      end
    end
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic spie);
    cpol_m = cpol; cpha_m = cpha;
    bus.sck_i = cpol;
    wb_write(2'd0, {spie, 1'b1, 2'b00, cpol, cpha, 2'b00});
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, m0: 8'h3C, m1: 8'hC3, s0: 8'hA5, s1: 8'h5A};
    vecs[1] = '{cpol: 1'b0, cpha: 1'b1, m0: 8'h81, m1: 8'h7E, s0: 8'h7E, s1: 8'h81};
    vecs[2] = '{cpol: 1'b1, cpha: 1'b0, m0: 8'h81, m1: 8'h7E, s0: 8'h7E, s1: 8'h81};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b1, m0: 8'h81, m1: 8'h7E, s0: 8'h7E, s1: 8'h81};

    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = 2'd0; bus.dat_i = 8'h00;
    bus.sck_i = 1'b0; bus.ss_i = 1'b1; bus.mosi_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dat_o", bus.dat_o, 8'h00);
    check("rst_ack", {7'b0, bus.ack_o}, 8'h00);
    check("rst_inta", {7'b0, bus.inta_o}, 8'h00);
    check("rst_miso", {7'b0, bus.miso_o}, 8'h00);
    check("rst_miso_oe", {7'b0, bus.miso_oe_o}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wb_read(2'd0, d); check("rst_spcr", d, 8'h00);
    wb_read(2'd1, d); check("rst_spsr", d, 8'h05);
    wb_read(2'd3, d); check("rst_sper", d, 8'h00);

    // Mode 0 single byte with interrupt enabled.
    set_mode(1'b0, 1'b0, 1'b1);
    tx_write(8'hA5);
    exp_rx_q.push_back(8'h3C);
    ss_low();
    spi_byte(8'h3C, 8);
    ss_high();
    wb_read(2'd1, d); check("spsr_mode0", d, 8'h94);
    check("inta_set", {7'b0, bus.inta_o}, 8'h01);
    rx_read();
    wb_write(2'd1, 8'h90);
    check("inta_clr", {7'b0, bus.inta_o}, 8'h00);
    wb_read(2'd1, d); check("spsr_cleared", d, 8'h05);

    // Two-byte bursts in every mode.
    for (int i = 0; i < 4; i++) begin
      set_mode(vecs[i].cpol, vecs[i].cpha, 1'b0);
      wb_write(2'd1, 8'hF0);
      tx_write(vecs[i].s0);
      tx_write(vecs[i].s1);
      exp_rx_q.push_back(vecs[i].m0);
      exp_rx_q.push_back(vecs[i].m1);
      ss_low();
      spi_byte(vecs[i].m0, 8);
      spi_byte(vecs[i].m1, 8);
      ss_high();
      rx_read();
      rx_read();
      wb_read(2'd1, d); check("spsr_burst", d, 8'h95);
    end

    // TX underrun sends 0xFF and sets tund until written back.
    set_mode(1'b0, 1'b0, 1'b0);
    wb_write(2'd1, 8'hF0);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h99);
    ss_low();
    spi_byte(8'h99, 8);
    ss_high();
    wb_read(2'd1, d); check("tund_set", d & 8'h10, 8'h10);
    wb_write(2'd1, 8'h10);
    wb_read(2'd1, d); check("tund_clr", d & 8'h10, 8'h00);
    rx_read();

    // RX overrun: five bytes, no reads.
    wb_write(2'd1, 8'hF0);
    exp_rx_q.push_back(8'h11); exp_rx_q.push_back(8'h22);
    exp_rx_q.push_back(8'h33); exp_rx_q.push_back(8'h44);
    for (int i = 0; i < 5; i++) exp_miso_q.push_back(8'hFF);
    ss_low();
    spi_byte(8'h11, 8); spi_byte(8'h22, 8); spi_byte(8'h33, 8);
    spi_byte(8'h44, 8); spi_byte(8'h55, 8);
    ss_high();
    wb_read(2'd1, d); check("spsr_rovr", d, 8'hB6);
    for (int i = 0; i < 4; i++) rx_read();
    wb_read(2'd2, d); check("rx_stale_head", d, 8'h11);
    wb_read(2'd1, d); check("rx_empty_after_stale", d & 8'h03, 8'h01);

    // Partial byte is discarded, next byte lands normally.
    wb_write(2'd1, 8'hF0);
    ss_low();
    spi_byte(8'hC3, 4);
    ss_high();
    wb_read(2'd1, d); check("spsr_partial", d, 8'h15);
    tx_write(8'h5A);
    exp_rx_q.push_back(8'hA7);
    ss_low();
    spi_byte(8'hA7, 8);
    ss_high();
    rx_read();

    // TX overflow, then spe=0 clears the FIFOs and sticky flags.
    wb_write(2'd1, 8'hF0);
    for (int i = 0; i < 5; i++) wb_write(2'd2, 8'(i + 1));
    wb_read(2'd1, d); check("spsr_wcol", d, 8'h49);
    wb_write(2'd0, 8'h00);
    wb_read(2'd1, d); check("spsr_spe_off", d, 8'h05);

    // icnt=3: spif only after the fourth byte.
    wb_write(2'd3, 8'hC0);
    set_mode(1'b0, 1'b0, 1'b0);
    wb_read(2'd3, d); check("sper_rd", d, 8'hC0);
    for (int i = 0; i < 4; i++) exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h01); exp_rx_q.push_back(8'h02);
    exp_rx_q.push_back(8'h03); exp_rx_q.push_back(8'h04);
    ss_low();
    spi_byte(8'h01, 8); spi_byte(8'h02, 8); spi_byte(8'h03, 8);
    ss_high();
    wb_read(2'd1, d); check("spif_after_3", d & 8'h80, 8'h00);
    ss_low();
    spi_byte(8'h04, 8);
    ss_high();
    wb_read(2'd1, d); check("spif_after_4", d & 8'h80, 8'h80);
    for (int i = 0; i < 4; i++) rx_read();

    // Asynchronous reset in the middle of a byte.
    set_mode(1'b0, 1'b0, 1'b1);
    check("inta_pre_rst", {7'b0, bus.inta_o}, 8'h01);
    ss_low();
    spi_byte(8'h00, 3);
    check("miso_pre_rst", {7'b0, bus.miso_o}, 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_miso", {7'b0, bus.miso_o}, 8'h00);
    check("arst_miso_oe", {7'b0, bus.miso_oe_o}, 8'h00);
    check("arst_inta", {7'b0, bus.inta_o}, 8'h00);
    check("arst_ack", {7'b0, bus.ack_o}, 8'h00);
    check("arst_dat_o", bus.dat_o, 8'h00);
    bus.ss_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
